// File: rtl/pad_bidir_arbiter.sv
// Round-robin owner of one bidirectional pad group, with all-OE-low dead cycles between owners.
// Request to grant takes 1 cycle and read data takes 1 cycle; OE follows the owner's req combinationally, and there is no backpressure.
module pad_bidir_arbiter #(
    parameter int                 NREQ       = 4,
    parameter int                 WIDTH      = 8,
    parameter int                 PADATTR    = 16,
    parameter int                 TURNAROUND = 2,
    parameter int                 MAX_GRANT  = 16,
    parameter logic [PADATTR-1:0] ATTR_RST   = '0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NREQ-1:0]           req_i,
    output logic [NREQ-1:0]           gnt_o,
    output logic [$clog2(NREQ)-1:0]   owner_o,
    output logic                      busy_o,
    input  logic [NREQ*WIDTH-1:0]     drv_data_i,
    input  logic [NREQ*WIDTH-1:0]     drv_oe_i,
    input  logic [NREQ*PADATTR-1:0]   attr_i,
    output logic [WIDTH-1:0]          pad_in_o,
    output logic [WIDTH-1:0]          pad_oe_o,
    output logic [PADATTR-1:0]        pad_attributes_o,
    input  logic [WIDTH-1:0]          pad_out_i,
    output logic [WIDTH-1:0]          rd_data_o
);
    localparam int OW  = $clog2(NREQ);
    localparam int HCW = (MAX_GRANT > 0) ? $clog2(MAX_GRANT + 1) : 1;
    localparam int TCW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

    typedef enum logic [1:0] {S_IDLE, S_OWN, S_TURN} state_t;

    state_t              r_state;
    logic [NREQ-1:0]     r_gnt;
    logic [OW-1:0]       r_owner;
    logic [PADATTR-1:0]  r_attr;
    logic [WIDTH-1:0]    r_rd_data;
    logic [HCW-1:0]      r_hold_cnt;
    logic [TCW-1:0]      r_turn_cnt;

    logic [OW-1:0]       w_win;
    logic                w_any;
    logic [NREQ-1:0]     w_win_oh;
    logic                w_release;

    // Search upward from the slot after the last owner, so the last owner has the lowest priority.
    always_comb begin : p_arb
        int idx;
        w_win = r_owner;
        w_any = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(r_owner) + i) % NREQ;
            if (!w_any && req_i[idx]) begin
                w_win = OW'(idx);
                w_any = 1'b1;
            end
        end
        w_win_oh = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
    end

    always_comb begin
        w_release = !req_i[r_owner];
        if (MAX_GRANT != 0 && int'(r_hold_cnt) >= MAX_GRANT - 1 && |(req_i & ~r_gnt))
            w_release = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_owner    <= OW'(NREQ - 1);
            r_attr     <= ATTR_RST;
            r_rd_data  <= '0;
            r_hold_cnt <= '0;
            r_turn_cnt <= '0;
        end else begin
            r_rd_data <= pad_out_i;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state    <= S_OWN;
                        r_gnt      <= w_win_oh;
                        r_owner    <= w_win;
                        r_attr     <= attr_i[w_win*PADATTR +: PADATTR];
                        r_hold_cnt <= '0;
                    end
                end
                S_OWN: begin
                    if (r_hold_cnt != '1)
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    if (w_release) begin
                        r_gnt      <= '0;
                        r_turn_cnt <= '0;
                        r_state    <= (TURNAROUND == 0) ? S_IDLE : S_TURN;
                    end
                end
                S_TURN: begin
                    if (int'(r_turn_cnt) >= TURNAROUND - 1)
                        r_state <= S_IDLE;
                    else
                        r_turn_cnt <= r_turn_cnt + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // OE is gated by the live request so a release never drives for an extra cycle.
    always_comb begin
        pad_in_o = '0;
        pad_oe_o = '0;
        if (r_state == S_OWN) begin
            pad_in_o = drv_data_i[r_owner*WIDTH +: WIDTH];
            pad_oe_o = drv_oe_i[r_owner*WIDTH +: WIDTH] & {WIDTH{req_i[r_owner]}};
        end
    end

    assign gnt_o            = r_gnt;
    assign owner_o          = r_owner;
    assign busy_o           = (r_state != S_IDLE);
    assign pad_attributes_o = r_attr;
    assign rd_data_o        = r_rd_data;
endmodule

// File: tb/tb_pad_bidir_arbiter.sv
// Bench for pad_bidir_arbiter: default build plus a zero-turnaround build.
module tb_pad_bidir_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [3:0]  req   = '0;
    logic [3:0]  req_z = '0;
    logic [31:0] drv_data = '0;
    logic [31:0] drv_oe   = '0;
    logic [63:0] attr     = '0;
    logic [7:0]  pad_out  = '0;

    logic [3:0]  gnt,     gnt_z;
    logic [1:0]  owner,   owner_z;
    logic        busy,    busy_z;
    logic [7:0]  pad_in,  pad_in_z;
    logic [7:0]  pad_oe,  pad_oe_z;
    logic [15:0] pad_attr, pad_attr_z;
    logic [7:0]  rd_data, rd_data_z;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    pad_bidir_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req), .gnt_o(gnt), .owner_o(owner),
        .busy_o(busy), .drv_data_i(drv_data), .drv_oe_i(drv_oe), .attr_i(attr),
        .pad_in_o(pad_in), .pad_oe_o(pad_oe), .pad_attributes_o(pad_attr),
        .pad_out_i(pad_out), .rd_data_o(rd_data)
    );

    pad_bidir_arbiter #(.TURNAROUND(0)) dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_z), .gnt_o(gnt_z), .owner_o(owner_z),
        .busy_o(busy_z), .drv_data_i(drv_data), .drv_oe_i(drv_oe), .attr_i(attr),
        .pad_in_o(pad_in_z), .pad_oe_o(pad_oe_z), .pad_attributes_o(pad_attr_z),
        .pad_out_i(pad_out), .rd_data_o(rd_data_z)
    );

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  gnt;
        logic        busy;
        logic [7:0]  oe;
        logic [7:0]  din;
        logic [1:0]  owner;
        logic [15:0] attr;
    } vec_t;

    vec_t        tbl[12];
    vec_t        sbq[$];
    logic [7:0]  rdq[$];
    int          ordq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        req   = '0;
        req_z = '0;
        #1;
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int own1, first3, regain, held, e;
        logic [3:0] prev;

        for (int k = 0; k < 4; k++) begin
            drv_data[k*8 +: 8]  = 8'(8'hD0 + k);
            drv_oe[k*8 +: 8]    = 8'(8'h30 + k);
            attr[k*16 +: 16]    = 16'(16'hA000 + k);
        end

        // Reset values, held across a clock edge with live pad input.
        pad_out = 8'h5A;
        req     = 4'b1111;
        tick();
        chk("rst_gnt",   32'(gnt),      32'h0);
        chk("rst_owner", 32'(owner),    32'h3);
        chk("rst_busy",  32'(busy),     32'h0);
        chk("rst_oe",    32'(pad_oe),   32'h0);
        chk("rst_din",   32'(pad_in),   32'h0);
        chk("rst_attr",  32'(pad_attr), 32'h0);
        chk("rst_rd",    32'(rd_data),  32'h0);

        // Grant, release, turnaround, handover to requester 2.
        tbl[0]  = '{4'b0101, 4'b0000, 1'b0, 8'h00, 8'h00, 2'd3, 16'h0000};
        tbl[1]  = '{4'b0101, 4'b0001, 1'b1, 8'h30, 8'hD0, 2'd0, 16'hA000};
        tbl[2]  = '{4'b0101, 4'b0001, 1'b1, 8'h30, 8'hD0, 2'd0, 16'hA000};
        tbl[3]  = '{4'b0100, 4'b0001, 1'b1, 8'h00, 8'hD0, 2'd0, 16'hA000};
        tbl[4]  = '{4'b0100, 4'b0000, 1'b1, 8'h00, 8'h00, 2'd0, 16'hA000};
        tbl[5]  = '{4'b0100, 4'b0000, 1'b1, 8'h00, 8'h00, 2'd0, 16'hA000};
        tbl[6]  = '{4'b0100, 4'b0000, 1'b0, 8'h00, 8'h00, 2'd0, 16'hA000};
        tbl[7]  = '{4'b0100, 4'b0100, 1'b1, 8'h32, 8'hD2, 2'd2, 16'hA002};
        tbl[8]  = '{4'b0000, 4'b0100, 1'b1, 8'h00, 8'hD2, 2'd2, 16'hA002};
        tbl[9]  = '{4'b0000, 4'b0000, 1'b1, 8'h00, 8'h00, 2'd2, 16'hA002};
        tbl[10] = '{4'b0000, 4'b0000, 1'b1, 8'h00, 8'h00, 2'd2, 16'hA002};
        tbl[11] = '{4'b0000, 4'b0000, 1'b0, 8'h00, 8'h00, 2'd2, 16'hA002};

        do_reset();
        for (int c = 0; c < 12; c++) begin
            req = tbl[c].req;
            sbq.push_back(tbl[c]);
            #1;
            v = sbq.pop_front();
            chk($sformatf("tbl%0d_gnt", c),   32'(gnt),      32'(v.gnt));
            chk($sformatf("tbl%0d_busy", c),  32'(busy),     32'(v.busy));
            chk($sformatf("tbl%0d_oe", c),    32'(pad_oe),   32'(v.oe));
            chk($sformatf("tbl%0d_din", c),   32'(pad_in),   32'(v.din));
            chk($sformatf("tbl%0d_owner", c), 32'(owner),    32'(v.owner));
            chk($sformatf("tbl%0d_attr", c),  32'(pad_attr), 32'(v.attr));
            tick();
        end

        // Read path: one-cycle registered copy of pad_out.
        for (int c = 0; c < 6; c++) begin
            pad_out = 8'($urandom);
            rdq.push_back(pad_out);
            tick();
            chk($sformatf("rd%0d", c), 32'(rd_data), 32'(rdq.pop_front()));
        end

        // Preemption after 16 owned cycles, then the preempted requester regains.
        do_reset();
        req = 4'b0010; own1 = 0; first3 = -1; regain = -1;
        for (int c = 0; c < 80; c++) begin
            if (c == 5) req[3] = 1'b1;
            #1;
            if (first3 < 0 && gnt == 4'b0010) own1++;
            if (first3 < 0 && gnt == 4'b1000) first3 = c;
            if (first3 >= 0 && c == first3 + 3) req[3] = 1'b0;
            if (first3 >= 0 && gnt == 4'b0010) begin
                regain = c;
                break;
            end
            tick();
        end
        chk("pre_own_cycles", 32'(own1),   32'd16);
        chk("pre_gnt3_cycle", 32'(first3), 32'd20);
        chk("pre_regain",     32'(regain), 32'd27);

        // Round robin with every requester waiting; each owner releases after 2 cycles.
        do_reset();
        ordq = '{0, 1, 2, 3, 0};
        req = 4'b1111; prev = '0; held = 0;
        for (int c = 0; c < 200 && ordq.size() > 0; c++) begin
            tick();
            chk("rr_onehot", 32'($onehot0(gnt)), 32'd1);
            if (gnt == 4'b0000)
                chk("rr_idle_oe", 32'(pad_oe), 32'h0);
            if (gnt != 4'b0000) begin
                if (gnt != prev) begin
                    e = ordq.pop_front();
                    chk("rr_order", 32'(gnt), 32'(4'b0001 << e));
                    held = 0;
                end
                held++;
                if (held == 2) req[owner] = 1'b0;
            end else begin
                req = 4'b1111;
            end
            prev = gnt;
        end
        chk("rr_remaining", 32'(ordq.size()), 32'd0);

        // Zero-turnaround build: release at t, IDLE at t+1, new grant at t+2.
        do_reset();
        req_z = 4'b0101;
        #1;
        chk("z_c0_gnt", 32'(gnt_z), 32'h0);
        tick();
        chk("z_c1_gnt", 32'(gnt_z), 32'h1);
        chk("z_c1_oe",  32'(pad_oe_z), 32'h30);
        tick();
        req_z = 4'b0100;
        #1;
        chk("z_t_oe",   32'(pad_oe_z), 32'h0);
        chk("z_t_gnt",  32'(gnt_z), 32'h1);
        tick();
        chk("z_t1_busy", 32'(busy_z), 32'h0);
        chk("z_t1_gnt",  32'(gnt_z), 32'h0);
        chk("z_t1_oe",   32'(pad_oe_z), 32'h0);
        tick();
        chk("z_t2_gnt",  32'(gnt_z), 32'h4);
        chk("z_t2_oe",   32'(pad_oe_z), 32'h32);
        req_z = '0;

        // Reset asserted between clock edges while driving all pads.
        do_reset();
        drv_oe[7:0] = 8'hFF;
        req = 4'b0001;
        tick();
        tick();
        chk("mr_oe_before",   32'(pad_oe), 32'hFF);
        chk("mr_attr_before", 32'(pad_attr), 32'hA000);
        rst_i = 1'b1;
        #1;
        chk("mr_oe",    32'(pad_oe), 32'h0);
        chk("mr_attr",  32'(pad_attr), 32'h0);
        chk("mr_owner", 32'(owner), 32'h3);
        chk("mr_gnt",   32'(gnt), 32'h0);
        chk("mr_busy",  32'(busy), 32'h0);
        tick();
        rst_i = 1'b0;
        req   = '0;
        drv_oe[7:0] = 8'h30;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
